imem_prefetch_buffer: RTL and testbench



---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_prefetch_buffer_if.sv | 24 ++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/imem_prefetch_buffer.sv | 120 ++++++++++++
 tb/tb_imem_prefetch_buffer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package imem_pkg;

  typedef enum logic [0:0] {
    IDLE,
    REQ
  } fetch_state_t;

  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/imem_prefetch_buffer_if.sv
// Core fetch port and memory bus of the prefetch buffer; the buffer itself is the slave.
interface imem_prefetch_buffer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output imem_req, imem_addr, bus_gnt, bus_rvalid, bus_rdata, bus_err,
    input  imem_ready, imem_rdata, imem_err, bus_req, bus_addr
  );

  modport slave (
    input  imem_req, imem_addr, bus_gnt, bus_rvalid, bus_rdata, bus_err,
    output imem_ready, imem_rdata, imem_err, bus_req, bus_addr
  );
endinterface

// File: rtl/fetch_fifo.sv
// In-order FIFO of fetched words exposing the two oldest entries and the fill count.
module fetch_fifo
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             entry0,
  output fetch_entry_t             entry1,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  assign entry0 = mem_q[rd_ptr_q];
  assign entry1 = mem_q[rd_ptr_q + PW'(1)];
  assign count  = count_q;

endmodule

// File: rtl/imem_prefetch_buffer.sv
// Instruction prefetch buffer: serves core fetches from a FIFO of sequential words and
// refills it over a pipelined req/gnt/rvalid bus, flushing when the PC leaves the stream.
module imem_prefetch_buffer
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  imem_prefetch_buffer_if.slave ifc
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q;
  logic          bus_req_q, req_stale_q;
  logic [31:0]   head_addr_q, fetch_addr_q, req_addr_q;
  logic [CW-1:0] outstanding_q, discard_q;

  fetch_entry_t  entry0, entry1, push_data;
  logic [CW-1:0] count, count_d, outstanding_d, discard_d;
  logic [31:0]   addr_a, head_addr_d, fetch_addr_d;
  logic          hit0, hit1, wait_empty, miss, gnt_hs, rsp_drop, push, credit;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^ifc.imem_addr[1:0];

  always_comb begin
    addr_a     = {ifc.imem_addr[31:2], 2'b00};
    hit0       = ifc.imem_req && (count != '0) && (addr_a == head_addr_q);
    hit1       = ifc.imem_req && !hit0 && (count >= CW'(2)) &&
                 (addr_a == head_addr_q + WORD_BYTES);
    // Empty buffer on the expected address: the fill is coming, so wait rather than flush.
    wait_empty = (count == '0) && (addr_a == head_addr_q);
    miss       = ifc.imem_req && !hit0 && !hit1 && !wait_empty;

    gnt_hs    = bus_req_q && ifc.bus_gnt;
    rsp_drop  = ifc.bus_rvalid && (discard_q != '0);
    push      = ifc.bus_rvalid && !rsp_drop && !miss;
    push_data = '{data: ifc.bus_rdata, err: ifc.bus_err};

    outstanding_d = outstanding_q + CW'(gnt_hs) - CW'(ifc.bus_rvalid);
    // On a flush every read still in flight after this edge is stale.
    discard_d     = miss ? outstanding_d
                         : discard_q + CW'(gnt_hs && req_stale_q) - CW'(rsp_drop);
    count_d       = miss ? '0 : count + CW'(push) - CW'(hit1);

    head_addr_d  = miss ? addr_a : (hit1 ? head_addr_q + WORD_BYTES : head_addr_q);
    fetch_addr_d = miss ? addr_a
                 : (gnt_hs && !req_stale_q) ? fetch_addr_q + WORD_BYTES : fetch_addr_q;
    credit       = (32'(count_d) + 32'(outstanding_d)) < DEPTH;

    ifc.imem_ready = hit0 || hit1;
    ifc.imem_rdata = hit1 ? entry1.data : (hit0 ? entry0.data : '0);
    ifc.imem_err   = hit1 ? entry1.err  : (hit0 && entry0.err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b0;
      req_stale_q   <= 1'b0;
      req_addr_q    <= '0;
      head_addr_q   <= '0;
      fetch_addr_q  <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      head_addr_q   <= head_addr_d;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      unique case (state_q)
        IDLE: begin
          if (ifc.imem_req && credit) begin
            state_q     <= REQ;
            bus_req_q   <= 1'b1;
            req_addr_q  <= fetch_addr_d;
            req_stale_q <= 1'b0;
          end
        end
        REQ: begin
          if (ifc.bus_gnt) begin
            req_stale_q <= 1'b0;
            if (ifc.imem_req && credit) begin
              req_addr_q <= fetch_addr_d;
            end else begin
              state_q   <= IDLE;
              bus_req_q <= 1'b0;
            end
          end else if (miss) begin
            // Ungranted request is never retracted; its response will be dropped.
            req_stale_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign ifc.bus_req  = bus_req_q;
  assign ifc.bus_addr = req_addr_q;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (miss),
    .push     (push),
    .push_data(push_data),
    .pop      (hit1),
    .entry0   (entry0),
    .entry1   (entry1),
    .count    (count)
  );

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Directed plus randomized bench for imem_prefetch_buffer against an address-derived memory.
module tb_imem_prefetch_buffer;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_prefetch_buffer_if ifc ();

  imem_prefetch_buffer #(
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ifc(ifc.slave)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int unsigned gnt_pct = 100;
  int unsigned lat_lo  = 0;
  int unsigned lat_hi  = 0;
  bit          hold_gnt = 1'b0;
  logic [31:0] err_addr = 32'h1;

  rsp_t        q[$];
  logic [31:0] hs_log[$];
  logic [31:0] rv_addr_log[$];
  int          rv_cyc_log[$];

  logic        s_ready, s_err, s_bus_req, s_gnt, s_rvalid;
  logic [31:0] s_rdata, s_bus_addr;
  int          s_cyc;
  logic        prev_wait;
  logic [31:0] prev_addr;
  int          wait_n;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return 32'h13 + (a << 5);
  endfunction

  function automatic logic [31:0] hs_at(int i);
    if (i >= 0 && i < hs_log.size()) return hs_log[i];
    return 'x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive bus inputs, sample, run generic checks, advance the bus model.
  task automatic tick();
    logic [31:0] a;
    ifc.bus_gnt = ifc.bus_req && !hold_gnt && ($urandom_range(99) < gnt_pct);
    if (q.size() > 0 && q[0].due <= cyc) begin
      ifc.bus_rvalid = 1'b1;
      ifc.bus_rdata  = mem_word(q[0].addr);
      ifc.bus_err    = (q[0].addr == err_addr);
    end else begin
      ifc.bus_rvalid = 1'b0;
      ifc.bus_rdata  = $urandom;
      ifc.bus_err    = 1'($urandom_range(1));
    end
    #1;
    s_ready    = ifc.imem_ready;
    s_rdata    = ifc.imem_rdata;
    s_err      = ifc.imem_err;
    s_bus_req  = ifc.bus_req;
    s_bus_addr = ifc.bus_addr;
    s_gnt      = ifc.bus_gnt;
    s_rvalid   = ifc.bus_rvalid;
    s_cyc      = cyc;
    a = {ifc.imem_addr[31:2], 2'b00};
    if (!ifc.imem_req) check("ready_without_req", 32'(s_ready), 32'(0));
    if (s_ready) begin
      check("served_word", s_rdata, mem_word(a));
      check("served_err", 32'(s_err), 32'(a == err_addr));
    end
    if (prev_wait) begin
      check("req_held", 32'(s_bus_req), 32'(1));
      check("addr_held", s_bus_addr, prev_addr);
    end
    prev_wait = s_bus_req && !s_gnt;
    prev_addr = s_bus_addr;
    if (ifc.imem_req && !s_ready) begin
      wait_n++;
      if (wait_n > 80) begin
        check("wait_bound", 32'(wait_n), 32'(80));
        wait_n = 0;
      end
    end else begin
      wait_n = 0;
    end
    @(posedge clk);
    cyc++;
    if (s_rvalid) begin
      rv_addr_log.push_back(q[0].addr);
      rv_cyc_log.push_back(s_cyc);
      void'(q.pop_front());
    end
    if (s_bus_req && s_gnt) begin
      hs_log.push_back(s_bus_addr);
      q.push_back('{addr: s_bus_addr, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
      check("max_outstanding", 32'(q.size() <= DEPTH), 32'(1));
    end
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    ifc.bus_gnt    = 1'b0;
    ifc.bus_rvalid = 1'b0;
    #1;
    check("rst_imem_ready", 32'(ifc.imem_ready), 32'(0));
    check("rst_imem_rdata", ifc.imem_rdata, 32'(0));
    check("rst_imem_err", 32'(ifc.imem_err), 32'(0));
    check("rst_bus_req", 32'(ifc.bus_req), 32'(0));
    check("rst_bus_addr", ifc.bus_addr, 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst           = 1'b0;
    ifc.imem_req  = 1'b0;
    ifc.imem_addr = '0;
    q.delete();
    hs_log.delete();
    rv_addr_log.delete();
    rv_cyc_log.delete();
    prev_wait = 1'b0;
    wait_n    = 0;
    cyc       = 0;
    s_ready   = 1'b0;
  endtask

  task automatic fetch_at(input logic [31:0] a);
    ifc.imem_req  = 1'b1;
    ifc.imem_addr = a;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_ready) break;
    end
    check("fetch_ready", 32'(s_ready), 32'(1));
  endtask

  initial begin
    int          last_stale;
    int unsigned r;
    logic [31:0] pc;
    ifc.imem_req   = 1'b0;
    ifc.imem_addr  = '0;
    ifc.bus_gnt    = 1'b0;
    ifc.bus_rvalid = 1'b0;
    ifc.bus_rdata  = '0;
    ifc.bus_err    = 1'b0;
    do_reset();

    // Cold start on a zero-wait bus.
    ifc.imem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cold_not_ready", 32'(s_ready), 32'(0));
      if (i == 1) begin
        check("cold_bus_req", 32'(s_bus_req), 32'(1));
        check("cold_bus_addr", s_bus_addr, 32'(0));
      end
    end
    tick();
    check("cold_ready", 32'(s_ready), 32'(1));
    check("cold_word", s_rdata, 32'h13);
    for (int k = 1; k <= 8; k++) begin
      ifc.imem_addr = 32'(4 * k);
      tick();
      check("seq_ready", 32'(s_ready), 32'(1));
    end

    // Branch flush with reads in flight.
    do_reset();
    lat_lo = 2;
    lat_hi = 2;
    fetch_at(32'h0);
    fetch_at(32'h4);
    fetch_at(32'h100);
    check("flush_word", s_rdata, mem_word(32'h100));
    last_stale = -1;
    foreach (rv_addr_log[i])
      if (rv_addr_log[i] < 32'h100 && rv_cyc_log[i] > last_stale) last_stale = rv_cyc_log[i];
    check("flush_latency", 32'((s_cyc - last_stale) <= 3), 32'(1));
    lat_lo = 0;
    lat_hi = 0;

    // Grant withheld, then a flush while the request is still pending.
    do_reset();
    hold_gnt     = 1'b1;
    ifc.imem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) ifc.imem_addr = 32'h40;
      tick();
      if (i >= 1) begin
        check("bp_req", 32'(s_bus_req), 32'(1));
        check("bp_addr", s_bus_addr, 32'(0));
      end
    end
    hold_gnt = 1'b0;
    fetch_at(32'h40);
    check("bp_word", s_rdata, mem_word(32'h40));
    check("bp_first_grant", hs_at(0), 32'h0);
    check("bp_next_grant", hs_at(1), 32'h40);

    // Core stall: buffer fills and requests stop.
    do_reset();
    fetch_at(32'h0);
    fetch_at(32'h4);
    fetch_at(32'h8);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_ready", 32'(s_ready), 32'(1));
      check("stall_word", s_rdata, mem_word(32'h8));
    end
    check("stall_bus_req", 32'(s_bus_req), 32'(0));
    check("stall_in_flight", 32'(q.size()), 32'(0));
    check("stall_last_grant", hs_at(hs_log.size() - 1), 32'(8 + 4 * (DEPTH - 1)));

    // Error word.
    do_reset();
    err_addr = 32'hC;
    fetch_at(32'h0);
    fetch_at(32'h4);
    fetch_at(32'h8);
    fetch_at(32'hC);
    check("err_set", 32'(s_err), 32'(1));
    fetch_at(32'h10);
    check("err_clear", 32'(s_err), 32'(0));

    // Address wrap, then reset mid-burst.
    do_reset();
    err_addr = 32'h1;
    fetch_at(32'hFFFF_FFF8);
    check("miss_penalty", 32'(s_cyc), 32'(3));
    fetch_at(32'hFFFF_FFFC);
    fetch_at(32'h0);
    check("wrap_word", s_rdata, mem_word(32'h0));
    check("wrap_grant0", hs_at(0), 32'hFFFF_FFF8);
    check("wrap_grant1", hs_at(1), 32'hFFFF_FFFC);
    check("wrap_grant2", hs_at(2), 32'h0);
    do_reset();

    // Randomized traffic: sequential runs, holds, jumps, idle cycles, bus stalls.
    err_addr = 32'h2C;
    pc       = '0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) begin
        gnt_pct = $urandom_range(100, 40);
        lat_hi  = $urandom_range(3);
      end
      r = $urandom_range(99);
      if (r < 8) begin
        ifc.imem_req = 1'b0;
      end else begin
        ifc.imem_req = 1'b1;
        if (s_ready && r < 80) pc = pc + 32'h4;
        else if (r >= 94) pc = {22'h0, 8'($urandom_range(255)), 2'b00};
        ifc.imem_addr = pc | 32'($urandom_range(3));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
